// File: rtl/onehot_to_thermo_stream_if.sv
// Stream interface for the one-hot to thermometer converter.
// master: upstream producer / downstream consumer side; slave: the converter.
interface onehot_to_thermo_stream_if #(
  parameter int unsigned OH_W = 16
);
  localparam int unsigned TW = OH_W - 1;

  logic            in_valid;
  logic [OH_W-1:0] in_onehot;
  logic            in_ready;
  logic            out_valid;
  logic [TW-1:0]   out_thermo;
  logic            out_err;
  logic            out_ready;

  modport master (
    output in_valid, in_onehot, out_ready,
    input  in_ready, out_valid, out_thermo, out_err
  );

  modport slave (
    input  in_valid, in_onehot, out_ready,
    output in_ready, out_valid, out_thermo, out_err
  );
endinterface

// File: rtl/onehot_to_thermo_stream.sv
// One-hot to thermometer converter with a 2-entry output FIFO.
// Optional feature macro: ONEHOT_ERR_CNT_EN enables the saturating invalid-word
// counter on err_cnt (cleared by err_clr); otherwise err_cnt is tied to 0.
module onehot_to_thermo_stream #(
  parameter int unsigned OH_W      = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_to_thermo_stream_if.slave s,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int unsigned TW = OH_W - 1;

  logic [TW-1:0] mem_thermo [2];
  logic [1:0]    mem_err;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ;

  logic          push_c;
  logic          pop_c;
  logic          onehot_ok_c;
  logic [TW-1:0] conv_thermo_c;
  logic          conv_err_c;

  // Conversion: for a single set bit 2^k, 2^k - 1 is exactly k low-order ones.
  always_comb begin
    onehot_ok_c   = 1'b0;
    conv_thermo_c = '0;
    conv_err_c    = 1'b1;
    onehot_ok_c   = (s.in_onehot != '0) &&
                    ((s.in_onehot & (s.in_onehot - OH_W'(1))) == '0);
    if (onehot_ok_c) begin
      conv_thermo_c = TW'(s.in_onehot - OH_W'(1));
      conv_err_c    = 1'b0;
    end
  end

  // Handshake decode from registered occupancy; head entry drives the outputs.
  assign s.in_ready   = (occ < 2'd2);
  assign s.out_valid  = (occ != 2'd0);
  assign s.out_thermo = mem_thermo[rd_ptr];
  assign s.out_err    = mem_err[rd_ptr];
  assign push_c       = s.in_valid && s.in_ready;
  assign pop_c        = s.out_valid && s.out_ready;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_thermo[0] <= '0;
      mem_thermo[1] <= '0;
      mem_err       <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
    end else begin
      if (push_c) begin
        mem_thermo[wr_ptr] <= conv_thermo_c;
        mem_err[wr_ptr]    <= conv_err_c;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_c, pop_c})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef ONEHOT_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of invalid words accepted; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (push_c && conv_err_c && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`else
  logic unused_err_clr;

  // Counter disabled: constant zero, clear input has no effect.
  assign err_cnt        = '0;
  assign unused_err_clr = err_clr;
`endif
endmodule
